// File: rtl/vram_scanout.sv
// rtl/vram_scanout.sv - VGA-style raster scanout from 32-bit VRAM words, four 8-bit pixels per word
module vram_scanout #(
  parameter int          H_ACTIVE  = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        vram_re,
  output logic [31:0] vram_raddr,
  input  logic [31:0] vram_rdata,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  pixel,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [31:0]   ptr;

  logic h_last, v_last, active, fetch, hs_zone, vs_zone;

  assign h_last  = (hcnt == HW'(H_TOTAL - 1));
  assign v_last  = (vcnt == VW'(V_TOTAL - 1));
  assign active  = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
  assign fetch   = active && (hcnt[1:0] == 2'd0);
  assign hs_zone = (hcnt >= HW'(H_ACTIVE + H_FP)) && (hcnt < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_zone = (vcnt >= VW'(V_ACTIVE + V_FP)) && (vcnt < VW'(V_ACTIVE + V_FP + V_SYNC));

  // rst gates the strobe so the read port is idle without waiting for an edge
  assign vram_re    = enable && !rst && fetch;
  assign vram_raddr = ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
      ptr  <= BASE_ADDR;
    end else if (!enable) begin
      hcnt <= '0;
      vcnt <= '0;
      ptr  <= BASE_ADDR;
    end else begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + VW'(1);
      end else begin
        hcnt <= hcnt + HW'(1);
      end
      if (h_last && v_last)
        ptr <= BASE_ADDR;
      else if (vram_re)
        ptr <= ptr + 32'd1;
    end
  end

  // Stage 1: timing flags for the position one cycle back; read data arrives now
  logic       s1_de, s1_hs, s1_vs, s1_fs, s1_re;
  logic [1:0] s1_lane;
  logic [31:8] word_q;
  logic [7:0] lane_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_de   <= 1'b0;
      s1_hs   <= 1'b1;
      s1_vs   <= 1'b1;
      s1_fs   <= 1'b0;
      s1_re   <= 1'b0;
      s1_lane <= 2'd0;
      word_q  <= '0;
    end else if (!enable) begin
      s1_de   <= 1'b0;
      s1_hs   <= 1'b1;
      s1_vs   <= 1'b1;
      s1_fs   <= 1'b0;
      s1_re   <= 1'b0;
      s1_lane <= 2'd0;
    end else begin
      s1_de   <= active;
      s1_hs   <= !hs_zone;
      s1_vs   <= !vs_zone;
      s1_fs   <= (hcnt == '0) && (vcnt == '0);
      s1_re   <= vram_re;
      s1_lane <= hcnt[1:0];
      if (s1_re)
        word_q <= vram_rdata[31:8];
    end
  end

  // Lane 0 comes straight from the read port; lanes 1-3 from the held word
  always_comb begin
    lane_byte = 8'h00;
    case (s1_lane)
      2'd0: lane_byte = vram_rdata[7:0];
      2'd1: lane_byte = word_q[15:8];
      2'd2: lane_byte = word_q[23:16];
      2'd3: lane_byte = word_q[31:24];
      default: lane_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      pixel       <= 8'h00;
      frame_start <= 1'b0;
    end else if (!enable) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      pixel       <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      hsync       <= s1_hs;
      vsync       <= s1_vs;
      de          <= s1_de;
      pixel       <= s1_de ? lane_byte : 8'h00;
      frame_start <= s1_fs;
    end
  end

endmodule

// File: tb/tb_vram_scanout.sv
// tb/tb_vram_scanout.sv - directed self-checking bench for vram_scanout on a 14x7 raster
module tb_vram_scanout;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        vram_re;
  logic [31:0] vram_raddr;
  logic [31:0] vram_rdata;
  logic        hsync, vsync, de, frame_start;
  logic [7:0]  pixel;

  vram_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .BASE_ADDR(32'h100)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .vram_re(vram_re), .vram_raddr(vram_raddr), .vram_rdata(vram_rdata),
    .hsync(hsync), .vsync(vsync), .de(de), .pixel(pixel), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'h3, b + 8'h2, b + 8'h1, b};
  endfunction

  // Memory model: data valid only the cycle after a strobe; junk otherwise
  logic        override = 1'b0;
  logic        rd_valid = 1'b0;
  logic [31:0] rd_q = 32'h0;
  logic [31:0] junk = 32'h5A5A5A5A;
  always @(posedge clk) begin
    rd_valid <= vram_re;
    rd_q     <= (override && vram_raddr == 32'h100) ? 32'hAABBCCDD : word_of(vram_raddr);
    junk     <= $urandom;
  end
  assign vram_rdata = rd_valid ? rd_q : junk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        de;
    logic [7:0]  pix;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        re;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[16];
  int   fetches[2];
  int   fs_at[$];

  task automatic check_cycle(input int c);
    int p, h, v, hr, vr;
    logic e_de, e_re;
    logic [31:0] wa;
    logic [7:0]  e_pix;
    hr = c % 14;
    vr = (c / 14) % 7;
    e_re = (hr < 8) && (vr < 4) && (hr % 4 == 0);
    check($sformatf("re c=%0d", c), vram_re, e_re);
    if (e_re)
      check($sformatf("raddr c=%0d", c), vram_raddr, 32'h100 + vr * 2 + hr / 4);
    if (c >= 2) begin
      p = c - 2;
      h = p % 14;
      v = (p / 14) % 7;
      e_de = (h < 8) && (v < 4);
      wa = 32'h100 + v * 2 + h / 4;
      e_pix = e_de ? (wa[7:0] + 8'(h % 4)) : 8'h00;
      check($sformatf("de c=%0d", c), de, e_de);
      check($sformatf("pixel c=%0d", c), pixel, e_pix);
      check($sformatf("hsync c=%0d", c), hsync, !(h == 10 || h == 11));
      check($sformatf("vsync c=%0d", c), vsync, v != 5);
      check($sformatf("fs c=%0d", c), frame_start, (h == 0) && (v == 0));
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h101};
    tbl[2]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 32'h101};
    tbl[3]  = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 32'h101};
    tbl[4]  = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b1, 32'h101};
    tbl[5]  = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 32'h102};
    tbl[6]  = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 32'h102};
    tbl[7]  = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 32'h102};
    tbl[8]  = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 32'h102};
    tbl[9]  = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 32'h102};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h102};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h102};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h102};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h102};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 32'h102};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h103};
    fetches[0] = 0;
    fetches[1] = 0;

    // Mid-line reset: outputs go idle without a clock edge
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("de before reset", de, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst hsync", hsync, 1'b1);
    check("rst vsync", vsync, 1'b1);
    check("rst de", de, 1'b0);
    check("rst pixel", pixel, 8'h00);
    check("rst vram_re", vram_re, 1'b0);
    check("rst raddr", vram_raddr, 32'h100);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    for (int c = 0; c < 229; c++) begin
      if (vram_re && c < 196) fetches[c / 98]++;
      if (frame_start) fs_at.push_back(c);
      if (c < 16) begin
        check($sformatf("tbl de c=%0d", c), de, tbl[c].de);
        check($sformatf("tbl pixel c=%0d", c), pixel, tbl[c].pix);
        check($sformatf("tbl hsync c=%0d", c), hsync, tbl[c].hs);
        check($sformatf("tbl vsync c=%0d", c), vsync, tbl[c].vs);
        check($sformatf("tbl fs c=%0d", c), frame_start, tbl[c].fs);
        check($sformatf("tbl re c=%0d", c), vram_re, tbl[c].re);
        check($sformatf("tbl raddr c=%0d", c), vram_raddr, tbl[c].addr);
      end else begin
        check_cycle(c);
      end
      if (c == 98) check("ptr wrap c=98", vram_raddr, 32'h100);
      @(negedge clk);
      #1;
    end
    check("fetches frame0", fetches[0], 8);
    check("fetches frame1", fetches[1], 8);
    check("fs pulse count", fs_at.size(), 3);
    if (fs_at.size() >= 3) begin
      check("fs first", fs_at[0], 2);
      check("fs spacing 1", fs_at[1] - fs_at[0], 98);
      check("fs spacing 2", fs_at[2] - fs_at[1], 98);
    end

    // Enable drop at line 2, hcnt 5
    enable = 1'b0;
    #1;
    check("drop vram_re", vram_re, 1'b0);
    @(posedge clk);
    #1;
    check("drop de", de, 1'b0);
    check("drop pixel", pixel, 8'h00);
    check("drop hsync", hsync, 1'b1);
    check("drop vsync", vsync, 1'b1);
    check("drop fs", frame_start, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check("idle raddr", vram_raddr, 32'h100);
    check("idle vram_re", vram_re, 1'b0);
    check("idle de", de, 1'b0);

    // Re-raise with a distinct word 0; junk appears on non-capture cycles
    override = 1'b1;
    enable = 1'b1;
    #1;
    check("rise vram_re", vram_re, 1'b1);
    check("rise raddr", vram_raddr, 32'h100);
    @(negedge clk);
    #1;
    check("rise+1 fs", frame_start, 1'b0);
    check("rise+1 de", de, 1'b0);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] w;
      w = 32'hAABBCCDD;
      @(negedge clk);
      #1;
      check($sformatf("unpack fs k=%0d", k), frame_start, k == 0);
      check($sformatf("unpack de k=%0d", k), de, 1'b1);
      check($sformatf("unpack pixel k=%0d", k), pixel, w[8*k +: 8]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vram_scanout.md
# vram_scanout

Display-side reader for the video RAM that the pipelined CPU writes through its `vramaddr`/`vramwe`/`vramdata` port. It generates VGA-style raster timing, fetches 32-bit VRAM words ahead of the beam over a read port with 1-cycle latency, and unpacks each word into four 8-bit pixels. One pixel is emitted per `clk`. A CPU write to VRAM becomes visible on screen at the next scan of that location.

## Interface
- `H_ACTIVE`, 640, visible pixels per line; multiple of 4
- `H_FP`, 16, horizontal front porch, in cycles
- `H_SYNC`, 96, horizontal sync width, in cycles
- `H_BP`, 48, horizontal back porch, in cycles
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch, in lines
- `V_SYNC`, 2, vertical sync width, in lines
- `V_BP`, 33, vertical back porch, in lines
- `BASE_ADDR`, 0, VRAM word address of pixel (0,0)

Ports:
- `clk  in  1`  single clock; also the pixel clock
- `rst  in  1`  reset; asynchronous, active-high
- `enable  in  1`  scan enable
- `vram_re  out  1`  read strobe to VRAM
- `vram_raddr  out  32`  VRAM word address
- `vram_rdata  in  32`  read data; valid the cycle after `vram_re`
- `hsync  out  1`  horizontal sync, active-low
- `vsync  out  1`  vertical sync, active-low
- `de  out  1`  display enable (active pixel)
- `pixel  out  8`  pixel value
- `frame_start  out  1`  1-cycle pulse, aligned with pixel (0,0)

## Operation
**Totals.** H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.

**Counters.** `hcnt` runs 0..H_TOTAL-1. `vcnt` increments when `hcnt` wraps and runs 0..V_TOTAL-1.

**Active area.** A position is active when hcnt<H_ACTIVE and vcnt<V_ACTIVE.

**Sync.**
- hsync is low for H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC.
- vsync is low for V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC, for whole lines.

**Fetch.**
- `vram_re`=1 exactly on active positions with hcnt[1:0]==0.
- `vram_raddr` equals the internal word pointer. The pointer increments after each fetch.
- The pointer reloads BASE_ADDR when the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- No multiplier is used. Fetches per frame = H_ACTIVE*V_ACTIVE/4.

**Unpack.**
- The word is captured the cycle after the fetch.
- Pixel for hcnt%4 = k is `vram_rdata[8k+7:8k]`, little-endian byte lanes.
- The word register holds its value for the remaining 3 pixels.

**Blanking.** `pixel`=0 whenever `de`=0. `vram_rdata` is ignored outside capture cycles.

**Enable.**
- `enable`=0 holds the counters at (0,0), the pointer at BASE_ADDR, and `vram_re` at 0.
- It also clears the output pipeline, so outputs are idle from the next edge.
- When `enable` rises, scan starts at (0,0) in that cycle.

**Reset.**
- Counters = (0,0), pointer = BASE_ADDR, pipeline cleared.
- Idle outputs: hsync=1, vsync=1, de=0, pixel=0, vram_re=0, vram_raddr=BASE_ADDR, frame_start=0.
- Outputs take these values immediately on `rst`, without waiting for a clock edge.
- Reset mid-frame abandons the frame. Scan resumes at (0,0) on the first edge after release if `enable`=1.

## Timing
- `vram_re`/`vram_raddr` are combinational from the counters and pointer, in the same cycle as the counter position.
- `vram_rdata` is sampled at the end of the cycle after the fetch.
- Outputs hsync, vsync, de, pixel and frame_start are registered. They appear 2 cycles after their counter position, and all five stay mutually aligned.
- Pixel (0,0) appears on outputs 2 cycles after the counters are at (0,0).
- Pixel period is 1 cycle. Line period is H_TOTAL cycles. Frame period is H_TOTAL*V_TOTAL cycles.
- `frame_start`=1 only on the output cycle of position (0,0).

## Test plan
Common setup for all scenarios:
- Parameters: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=14); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7).
- BASE_ADDR=0x100.
- Memory model returns {addr[7:0]+8'h3, addr[7:0]+8'h2, addr[7:0]+8'h1, addr[7:0]} one cycle after `vram_re`.

Scenarios:
1. **Reset:** assert `rst` mid-line → hsync=1, vsync=1, de=0, pixel=0, vram_re=0, vram_raddr=0x100 without a clock edge. Release with enable=1 → vram_re=1 with addr 0x100 in the first cycle.
2. **First line:** after release, de=1 in output cycles 2..9 → pixels 00,01,02,03,01,02,03,04. frame_start=1 only in cycle 2. Fetches at addr 0x100 and 0x101 only.
3. **Sync:** hsync=0 for exactly output cycles 12,13 of each 14-cycle line. vsync=0 for the 14 cycles of line 5. de=0 on lines 4-6.
4. **Frame wrap:** run 2 frames → exactly 8 fetches per frame, addr 0x100..0x107. The pointer returns to 0x100 at cycle 98. frame_start pulses 98 cycles apart.
5. **Enable drop:** drop `enable` at hcnt=5 of line 2 → vram_re=0 immediately, and outputs idle from the next edge. Re-raise `enable` → the next fetch is addr 0x100, and frame_start follows 2 cycles later.
6. **Pixel unpack:** return 32'hAABBCCDD for word 0 → first four pixels DD,CC,BB,AA. Changing `vram_rdata` on non-capture cycles does not alter pixels.
